layer_code: RTL and testbench
=============================

Name: layer_code

Overview:
- Per-layer WS281x serial encoder.
- Holds a 64-entry pixel buffer written byte-wise by the upstream command/SPI decoder.
- On a write-done strobe, streams every pixel as WS281x NRZ code using run-time programmable T0H/T0L/T1H/T1L durations.
- Sits between the register/command layer and the LED strip output pin.

Parameters:
- ADDR_WIDTH, 6, pixel address width; buffer depth = 2**ADDR_WIDTH = 64 words.
- UNIT_CLKS, 2, clock cycles per timing-count unit (10 ns at 200 MHz).

Ports:
- clk_in  in  1  system clock (200 MHz nominal).
- rst_n_in  in  1  reset, synchronous, active-high (asserted when 1, despite the codebase's port name).
- wr_en_in  in  1  one-cycle buffer write strobe.
- wr_done_in  in  1  pulse: buffer update complete, start a frame.
- wr_addr_in  in  6  pixel word address.
- wr_data_in  in  8  byte written to every enabled lane.
- wr_byte_en_in  in  4  lane enables; bit3 = word[31:24] … bit0 = word[7:0].
- t0h_cnt_in  in  8  '0' bit high time, in units.
- t0l_cnt_in  in  8  '0' bit low time, in units.
- t1h_cnt_in  in  8  '1' bit high time, in units.
- t1l_cnt_in  in  8  '1' bit low time, in units.
- ws281x_code_out  out  1  serial LED data.

Behaviour:
- Buffer: 64 x 32-bit, simple dual-port, one write port, one read port.
  - Write: on clk when wr_en_in=1, every lane i with wr_byte_en_in[i]=1 takes wr_data_in; other lanes hold.
  - Writes accepted any time, including mid-frame.
  - Buffer contents not cleared by reset.
- Word format:
  - [31:24] = W/control byte, not transmitted in default build.
  - [23:0] = 24-bit colour, transmitted MSB first (bit 23 first).
- FSM states: IDLE, READ, SEND_H, SEND_L.
  - IDLE: output 0. wr_done_in=1 latches the four timing inputs, sets pixel index 0, goes to READ.
  - READ: one cycle; fetches word[index] into a shift register; bit counter = 24; goes to SEND_H.
  - SEND_H: output 1 for (bit ? t1h : t0h) * UNIT_CLKS cycles, then SEND_L.
  - SEND_L: output 0 for (bit ? t1l : t0l) * UNIT_CLKS cycles. Then:
    - if more bits remain in the word: shift and return to SEND_H;
    - else if index != 63: increment index and go to READ;
    - else: go to IDLE.
- Timing counts:
  - A count of 0 is treated as 1.
  - Maximum phase = 255 * UNIT_CLKS cycles.
  - Timing values are latched at frame start; changes mid-frame take effect on the next frame.
- Latency: wr_done_in sampled high at edge k gives ws281x_code_out=1 from edge k+2.
- Inter-word gap: READ adds one low cycle between pixels. Inter-pixel low time is therefore (tXl * UNIT_CLKS) + 1.
- wr_done_in while not IDLE is ignored; no queuing.
- Mid-frame writes: a pixel fetched in READ after the write transmits the new data.
- Frame end: output stays 0 in IDLE. The latch/reset gap is provided by the upstream idle time.
- Reset: state IDLE, ws281x_code_out=0, counters=0, latched timing=0. Reset mid-frame aborts immediately (output 0 on the next cycle).

Optional Feature:
- LAYER_CODE_RGBW_EN
  - Defined: each pixel sends all 32 bits, MSB first ([31:24] first).
  - Undefined: only [23:0] sent (24 bits/pixel).
  - Frame length and READ timing rules are otherwise unchanged.

Test Plan:
- Reset held 2 cycles -> ws281x_code_out=0, FSM IDLE; wr_done_in during reset is ignored.
- Timing t0h=1, t0l=0x7f, t1h=0x7f, t1l=1. Write addr0: lane3=0x01, lanes2:0=0x00. Write addr1: lane3=0x00, lanes2:0=0xFF. Pulse wr_done_in.
  - Pixel 0: 24 '0' bits, each 2 clk high / 254 clk low.
  - Pixel 1: 24 '1' bits, each 254 clk high / 2 clk low.
  - Output rises 2 cycles after wr_done.
- Continuous wr_done_in pulses every 2 cycles during that frame -> no restart. Frame completes in 64*(24*256+1) clk, then returns IDLE with output 0.
- Byte-enable check: write 0xAA with en=0100, then 0x55 with en=0011 to addr 5 -> pixel 5 colour 0xAA5555 on the wire.
- Reset asserted mid-bit while output is high -> output 0 next cycle. A new wr_done_in afterwards restarts from pixel 0.
- With LAYER_CODE_RGBW_EN: addr0 = 0x01000000 -> first 7 bits '0', 8th bit '1', then 24 '0' bits; 32 bits per pixel.

Source files
------------

// File: rtl/layer_code.sv
`timescale 1ns/1ps
// Per-layer WS281x encoder: 64-word pixel buffer streamed as NRZ code with programmable timing.
// Define LAYER_CODE_RGBW_EN to transmit all 32 bits per pixel instead of the 24-bit colour.
module layer_code #(
  parameter int ADDR_WIDTH = 6,
  parameter int UNIT_CLKS  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  wr_en_in,
  input  logic                  wr_done_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [7:0]            wr_data_in,
  input  logic [3:0]            wr_byte_en_in,
  input  logic [7:0]            t0h_cnt_in,
  input  logic [7:0]            t0l_cnt_in,
  input  logic [7:0]            t1h_cnt_in,
  input  logic [7:0]            t1l_cnt_in,
  output logic                  ws281x_code_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef LAYER_CODE_RGBW_EN
  localparam int BITS = 32;
`else
  localparam int BITS = 24;
`endif
  localparam int PW = $clog2(255 * UNIT_CLKS + 1);
  localparam int BW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, READ, SEND_H, SEND_L} state_e;

  logic [31:0]           mem_q [DEPTH];
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [BITS-1:0]       shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [PW-1:0]         cnt_q;
  logic [7:0]            t0h_q, t0l_q, t1h_q, t1l_q;
  logic                  code_q;

  logic [31:0]     rd_word;
  logic [BITS-1:0] fetch_bits;
  logic [PW-1:0]   fetch_hi_last, cur_lo_last, next_hi_last;

  // Phase counters hold (cycles - 1); a programmed count of 0 behaves as 1 unit.
  function automatic logic [PW-1:0] phase_last(input logic [7:0] units);
    int u;
    u = (units == 8'd0) ? 1 : int'(units);
    return PW'(u * UNIT_CLKS - 1);
  endfunction

  // NOTE: the pixel buffer has no reset; clearing a RAM costs a port and the contents are
  // always rewritten by the command layer before they matter.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_byte_en_in[i]) mem_q[wr_addr_in][8*i +: 8] <= wr_data_in;
      end
    end
  end

  assign rd_word    = mem_q[idx_q];
  assign fetch_bits = rd_word[BITS-1:0];

`ifndef LAYER_CODE_RGBW_EN
  logic unused_ctrl_byte;
  assign unused_ctrl_byte = ^rd_word[31:24];
`endif

  assign fetch_hi_last = fetch_bits[BITS-1] ? phase_last(t1h_q) : phase_last(t0h_q);
  assign cur_lo_last   = shift_q[BITS-1]    ? phase_last(t1l_q) : phase_last(t0l_q);
  assign next_hi_last  = shift_q[BITS-2]    ? phase_last(t1h_q) : phase_last(t0h_q);

  // The output register follows the state one cycle later, so every phase keeps its exact length.
  always_ff @(posedge clk_in) begin
    if (rst_n_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      t0h_q     <= '0;
      t0l_q     <= '0;
      t1h_q     <= '0;
      t1l_q     <= '0;
      code_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          code_q <= 1'b0;
          if (wr_done_in) begin
            t0h_q   <= t0h_cnt_in;
            t0l_q   <= t0l_cnt_in;
            t1h_q   <= t1h_cnt_in;
            t1l_q   <= t1l_cnt_in;
            idx_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          code_q    <= 1'b0;
          shift_q   <= fetch_bits;
          bit_cnt_q <= BW'(BITS - 1);
          cnt_q     <= fetch_hi_last;
          state_q   <= SEND_H;
        end
        SEND_H: begin
          code_q <= 1'b1;
          if (cnt_q == '0) begin
            cnt_q   <= cur_lo_last;
            state_q <= SEND_L;
          end else begin
            cnt_q <= cnt_q - PW'(1);
          end
        end
        SEND_L: begin
          code_q <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - PW'(1);
          end else if (bit_cnt_q != '0) begin
            shift_q   <= shift_q << 1;
            bit_cnt_q <= bit_cnt_q - BW'(1);
            cnt_q     <= next_hi_last;
            state_q   <= SEND_H;
          end else if (idx_q != '1) begin
            idx_q   <= idx_q + ADDR_WIDTH'(1);
            state_q <= READ;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ws281x_code_out = code_q;

endmodule

// File: tb/tb_layer_code.sv
`timescale 1ns/1ps
// Directed bench for layer_code: decodes the serial output into high/low run lengths
// and compares them against hand-computed pixel words and timing.
module tb_layer_code;

`ifdef LAYER_CODE_RGBW_EN
  localparam int BITS = 32;
  localparam logic [31:0] PX0_EXP  = 32'h0100_0000;
  localparam logic [31:0] PX1_EXP  = 32'h00FF_FFFF;
  localparam logic [31:0] PX5_EXP  = 32'hC4AA_5555;
  localparam logic [31:0] PX40_EXP = 32'hC33C_C33C;
`else
  localparam int BITS = 24;
  localparam logic [31:0] PX0_EXP  = 32'h0000_0000;
  localparam logic [31:0] PX1_EXP  = 32'h00FF_FFFF;
  localparam logic [31:0] PX5_EXP  = 32'h00AA_5555;
  localparam logic [31:0] PX40_EXP = 32'h003C_C33C;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_done = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] wr_be = '0;
  logic [7:0] t0h = '0, t0l = '0, t1h = '0, t1l = '0;
  logic       code;

  always #5 clk = ~clk;

  layer_code #(.ADDR_WIDTH(6), .UNIT_CLKS(2)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst),
    .wr_en_in        (wr_en),
    .wr_done_in      (wr_done),
    .wr_addr_in      (wr_addr),
    .wr_data_in      (wr_data),
    .wr_byte_en_in   (wr_be),
    .t0h_cnt_in      (t0h),
    .t0l_cnt_in      (t0l),
    .t1h_cnt_in      (t1h),
    .t1l_cnt_in      (t1l),
    .ws281x_code_out (code)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Run-length monitor of the serial line, sampled on the falling edge.
  typedef struct {logic lvl; int len;} run_t;
  run_t runs[$];
  bit   mon_en = 1'b0;
  logic prev_lvl = 1'b0;
  int   run_len = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (code === prev_lvl) run_len++;
      else begin
        runs.push_back('{prev_lvl, run_len});
        prev_lvl = code;
        run_len  = 1;
      end
    end
  end

  task automatic mon_restart();
    mon_en = 1'b0;
    runs.delete();
    prev_lvl = 1'b0;
    run_len  = 0;
    mon_en   = 1'b1;
  endtask

  logic [31:0] model [64];
  logic [31:0] exp_w [64];

  task automatic write_lane(input int addr, input logic [7:0] data, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = 6'(addr); wr_data = data; wr_be = be;
    for (int i = 0; i < 4; i++) if (be[i]) model[addr][8*i +: 8] = data;
    @(negedge clk);
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic set_timing(input logic [7:0] a, b, c, d);
    t0h = a; t0l = b; t1h = c; t1l = d;
  endtask

  task automatic pulse_done();
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  // Counts run-length entries that disagree with exp_w for the first n_bits transmitted bits.
  task automatic count_bad(input int n_bits, input int hi0, lo0, hi1, lo1, output int bad);
    bad = 0;
    for (int k = 0; k < n_bits; k++) begin
      int p, j, idx, ehi, elo;
      logic b;
      p = k / BITS; j = k % BITS;
      b = exp_w[p][BITS-1-j];
      ehi = b ? hi1 : hi0;
      elo = (b ? lo1 : lo0) + ((j == BITS - 1) ? 1 : 0);
      idx = 1 + 2 * k;
      if (idx >= runs.size()) bad++;
      else begin
        if (runs[idx].lvl !== 1'b1 || runs[idx].len != ehi) bad++;
        if (idx + 1 < runs.size() && runs[idx+1].len != elo) bad++;
      end
    end
  endtask

  function automatic logic [31:0] decode_px(input int p, input int hi1);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < BITS; j++) begin
      int idx;
      idx = 1 + 2 * (p * BITS + j);
      if (idx < runs.size() && runs[idx].len == hi1) r[BITS-1-j] = 1'b1;
    end
    return r;
  endfunction

  bit pulsing;
  int seen, bad, hold;

  initial begin
    // Reset with a start request present: the request must be dropped.
    @(negedge clk);
    rst = 1'b1; wr_done = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(code), 32'd0);
    rst = 1'b0; wr_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (code !== 1'b0) seen++;
    end
    check("rst_done_ignored", 32'(seen), 32'd0);

    for (int i = 0; i < 64; i++) write_lane(i, 8'(i * 37 + 11), 4'hF);
    write_lane(0, 8'h01, 4'b1000);
    write_lane(0, 8'h00, 4'b0111);
    write_lane(1, 8'h00, 4'b1000);
    write_lane(1, 8'hFF, 4'b0111);
    write_lane(5, 8'hAA, 4'b0100);
    write_lane(5, 8'h55, 4'b0011);

    // Slow frame: check latency and exact bit timing, then abort it with reset.
    set_timing(8'd1, 8'h7f, 8'h7f, 8'd1);
    for (int i = 0; i < 64; i++) exp_w[i] = model[i];
    mon_restart();
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    check("lat_k", 32'(code), 32'd0);
    @(negedge clk);
    check("lat_k1", 32'(code), 32'd0);
    @(negedge clk);
    check("lat_k2", 32'(code), 32'd1);

    hold = 0;
    while (hold < 14000 && !(runs.size() == 4 * BITS - 1 && code === 1'b1)) begin
      @(negedge clk);
      hold++;
    end
    check("slow_reach_p1_last", 32'(hold < 14000), 32'd1);
    mon_en = 1'b0;
    check("high_before_rst", 32'(code), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", 32'(code), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    check("p0_b0_hi", 32'(runs[1].len), 32'd2);
    check("p0_b0_lo", 32'(runs[2].len), 32'd254);
    check("p0_gap_lo", 32'(runs[2*BITS].len), 32'd255);
    check("p1_b0_hi", 32'(runs[2*BITS+1].len), exp_w[1][BITS-1] ? 32'd254 : 32'd2);
    count_bad(2 * BITS - 1, 2, 254, 254, 2, bad);
    check("slow_runs_bad", 32'(bad), 32'd0);
    check("slow_px0", decode_px(0, 254), PX0_EXP);

    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (code !== 1'b0) seen++;
    end
    check("idle_after_abort", 32'(seen), 32'd0);

    // Fast full frame: zero count -> one unit, repeated start requests, mid-frame writes/timing.
    set_timing(8'd0, 8'd2, 8'd2, 8'd1);
    for (int i = 0; i < 64; i++) exp_w[i] = model[i];
    mon_restart();
    pulse_done();
    pulsing = 1'b1;
    fork
      begin
        int c;
        c = 0;
        while (runs.size() < 2 * 64 * BITS - 200 && c < 20000) begin
          wr_done = 1'b1;
          @(negedge clk);
          wr_done = 1'b0;
          @(negedge clk);
          c += 2;
        end
        pulsing = 1'b0;
      end
    join_none
    set_timing(8'h7f, 8'h7f, 8'h7f, 8'h7f);
    hold = 0;
    while (hold < 1000 && runs.size() < 10) begin
      @(negedge clk);
      hold++;
    end
    write_lane(0, 8'h5A, 4'hF);
    write_lane(40, 8'h3C, 4'b0101);
    write_lane(40, 8'hC3, 4'b1010);
    exp_w[40] = model[40];

    hold = 0;
    while (hold < 20000 && runs.size() < 2 * 64 * BITS) begin
      @(negedge clk);
      hold++;
    end
    check("fast_frame_done", 32'(hold < 20000), 32'd1);
    repeat (100) @(negedge clk);
    check("fast_run_count", 32'(runs.size()), 32'(2 * 64 * BITS));
    check("fast_idle_out", 32'(code), 32'd0);
    check("fast_pulser_stopped", 32'(pulsing), 32'd0);
    count_bad(64 * BITS, 2, 4, 4, 2, bad);
    check("fast_runs_bad", 32'(bad), 32'd0);
    check("fast_px0_old", decode_px(0, 4), PX0_EXP);
    check("fast_px1", decode_px(1, 4), PX1_EXP);
    check("fast_px5_byte_en", decode_px(5, 4), PX5_EXP);
    check("fast_px40_new", decode_px(40, 4), PX40_EXP);
    check("fast_gap_p0", 32'(runs[2*BITS].len), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
